// File: rtl/vector_lane_sequencer.sv
// Element-pair sequencer feeding the two vector lanes: captures vl/vm/mask on start,
// then presents one element per lane per accepted cycle and pulses done after the last pair.
module vector_lane_sequencer #(
    parameter int NUM_LANES = 2,
    parameter int VLMAX     = 32
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       start,
    input  logic [$clog2(VLMAX):0]     vl,
    input  logic                       vm,
    input  logic [VLMAX-1:0]           mask_bits,
    input  logic                       lane_busy,
    input  logic                       stall_e_m,
    input  logic                       flush,
    output logic                       issue_valid,
    output logic [$clog2(VLMAX)-1:0]   elem_idx0,
    output logic [$clog2(VLMAX)-1:0]   elem_idx1,
    output logic [NUM_LANES-1:0]       lane_ena,
    output logic [NUM_LANES-1:0]       lane_mask,
    output logic                       first,
    output logic                       last,
    output logic                       busy,
    output logic                       done
);
    localparam int IW = $clog2(VLMAX);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IW:0]      base_q, base_d;
    logic [IW:0]      vl_q, vl_d;
    logic             vm_q, vm_d;
    logic [VLMAX-1:0] mask_q, mask_d;

    logic        ready;
    logic        in_issue;
    logic        last_pair;
    logic [IW:0] vl_clamp;
    logic [IW:0] base_next;

    assign ready     = !lane_busy && !stall_e_m;
    assign in_issue  = (state_q == S_ISSUE);
    assign base_next = base_q + (IW+1)'(NUM_LANES);
    // Indices are one bit wider than an element index so base+2 never wraps below vl_q.
    assign last_pair = (base_next >= vl_q);
    assign vl_clamp  = (vl > (IW+1)'(VLMAX)) ? (IW+1)'(VLMAX) : vl;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        vl_d    = vl_q;
        vm_d    = vm_q;
        mask_d  = mask_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        vl_d    = vl_clamp;
                        vm_d    = vm;
                        mask_d  = mask_bits;
                        base_d  = '0;
                        state_d = (vl_clamp != '0) ? S_ISSUE : S_DONE;
                    end
                end
                S_ISSUE: begin
                    if (ready) begin
                        if (last_pair) state_d = S_DONE;
                        else           base_d  = base_next;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            vl_q    <= '0;
            vm_q    <= 1'b0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            vl_q    <= vl_d;
            vm_q    <= vm_d;
            mask_q  <= mask_d;
        end
    end

    // Outputs decode only registered state; lane_busy/stall_e_m never reach them.
    always_comb begin
        logic [IW:0] idx;
        lane_ena  = '0;
        lane_mask = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            idx          = base_q + (IW+1)'(i);
            lane_ena[i]  = in_issue && (idx < vl_q);
            lane_mask[i] = lane_ena[i] && (vm_q || mask_q[idx[IW-1:0]]);
        end
    end

    assign issue_valid = in_issue;
    assign elem_idx0   = in_issue ? base_q[IW-1:0] : '0;
    assign elem_idx1   = in_issue ? (base_q[IW-1:0] + IW'(1)) : '0;
    assign first       = in_issue && (base_q == '0);
    assign last        = in_issue && last_pair;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// Randomized scoreboard bench for vector_lane_sequencer: the driver pushes the expected
// pair sequence per instruction, a negedge monitor checks every presented cycle against it.
module tb_vector_lane_sequencer;
  logic        CLK = 1'b0;
  logic        nRST;
  logic        start;
  logic [5:0]  vl;
  logic        vm;
  logic [31:0] mask_bits;
  logic        lane_busy;
  logic        stall_e_m;
  logic        flush;
  logic        issue_valid;
  logic [4:0]  elem_idx0;
  logic [4:0]  elem_idx1;
  logic [1:0]  lane_ena;
  logic [1:0]  lane_mask;
  logic        first;
  logic        last;
  logic        busy;
  logic        done;

  vector_lane_sequencer #(.NUM_LANES(2), .VLMAX(32)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .vl(vl), .vm(vm), .mask_bits(mask_bits),
    .lane_busy(lane_busy), .stall_e_m(stall_e_m), .flush(flush),
    .issue_valid(issue_valid), .elem_idx0(elem_idx0), .elem_idx1(elem_idx1),
    .lane_ena(lane_ena), .lane_mask(lane_mask), .first(first), .last(last),
    .busy(busy), .done(done)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic       is_done;
    logic [4:0] i0;
    logic [4:0] i1;
    logic [1:0] ena;
    logic [1:0] msk;
    logic       first;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  logic m_active = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the instruction is a list of element pairs followed by a completion marker.
  function automatic void push_model(input logic [5:0] v, input logic m, input logic [31:0] mk);
    int   n;
    exp_t e;
    n = (int'(v) > 32) ? 32 : int'(v);
    for (int b = 0; b < n; b += 2) begin
      e        = '0;
      e.i0     = 5'(b);
      e.i1     = 5'(b + 1);
      e.ena[0] = 1'b1;
      e.ena[1] = (b + 1 < n);
      e.msk[0] = m | mk[b];
      e.msk[1] = e.ena[1] & (m | mk[b + 1]);
      e.first  = (b == 0);
      e.last   = (b + 2 >= n);
      exp_q.push_back(e);
    end
    e         = '0;
    e.is_done = 1'b1;
    exp_q.push_back(e);
  endfunction

  // monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        exp_q.delete();
        m_active = 1'b0;
        check("reset_outputs", 32'({issue_valid, elem_idx0, elem_idx1, lane_ena, lane_mask,
                                    first, last, busy, done}), 32'd0);
      end else if (!m_active) begin
        check("idle_valid", 32'(issue_valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        if (start && !flush) m_active = 1'b1;
      end else begin
        check("active_busy", 32'(busy), 32'd1);
        if (exp_q.size() == 0) begin
          check("queue_size", 32'(exp_q.size()), 32'd1);
          m_active = 1'b0;
        end else if (exp_q[0].is_done) begin
          check("done_pulse", 32'(done), 32'd1);
          check("done_valid", 32'(issue_valid), 32'd0);
          void'(exp_q.pop_front());
          m_active = 1'b0;
        end else begin
          e = exp_q[0];
          check("issue_valid", 32'(issue_valid), 32'd1);
          check("elem_idx0", 32'(elem_idx0), 32'(e.i0));
          check("elem_idx1", 32'(elem_idx1), 32'(e.i1));
          check("lane_ena", 32'(lane_ena), 32'(e.ena));
          check("lane_mask", 32'(lane_mask), 32'(e.msk));
          check("first", 32'(first), 32'(e.first));
          check("last", 32'(last), 32'(e.last));
          check("early_done", 32'(done), 32'd0);
          if (!lane_busy && !stall_e_m) void'(exp_q.pop_front());
        end
        if (flush) begin
          exp_q.delete();
          m_active = 1'b0;
        end
      end
    end
  end

  // driver: called at posedge+1 of an idle cycle, returns at posedge+1 of an idle cycle
  task automatic run_instr(input logic [5:0] vl_v, input logic vm_v, input logic [31:0] mask_v,
                           input bit rnd_ready, input int busy_from, input int busy_len,
                           input int flush_at, input int restart_at, input int reset_at);
    bit finished;
    finished  = 1'b0;
    start     = 1'b1;
    vl        = vl_v;
    vm        = vm_v;
    mask_bits = mask_v;
    lane_busy = 1'b0;
    stall_e_m = 1'b0;
    flush     = 1'b0;
    push_model(vl_v, vm_v, mask_v);
    for (int k = 1; k <= 300 && !finished; k++) begin
      @(posedge CLK);
      #1;
      start     = 1'b0;
      flush     = 1'b0;
      vl        = 6'($urandom);
      vm        = 1'($urandom);
      mask_bits = $urandom;
      if (!busy) begin
        finished = 1'b1;
      end else if (k == reset_at) begin
        #2 nRST = 1'b0;
        #1;
        check("async_reset", 32'({issue_valid, elem_idx0, elem_idx1, lane_ena, lane_mask,
                                  first, last, busy, done}), 32'd0);
        @(posedge CLK);
        #1 nRST = 1'b1;
        finished = 1'b1;
      end else begin
        lane_busy = rnd_ready ? ($urandom_range(0, 3) == 0) : (k >= busy_from && k < busy_from + busy_len);
        stall_e_m = rnd_ready ? ($urandom_range(0, 4) == 0) : 1'b0;
        flush     = (k == flush_at);
        if (k == restart_at) begin
          start = 1'b1;
          vl    = 6'($urandom_range(1, 40));
        end
      end
    end
    if (!finished) check("instr_timeout", 32'(busy), 32'd0);
    lane_busy = 1'b0;
    stall_e_m = 1'b0;
    flush     = 1'b0;
    start     = 1'b0;
  endtask

  initial begin
    nRST      = 1'b0;
    start     = 1'b0;
    vl        = '0;
    vm        = 1'b0;
    mask_bits = '0;
    lane_busy = 1'b0;
    stall_e_m = 1'b0;
    flush     = 1'b0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    @(posedge CLK);
    #1;
    run_instr(6'd8,  1'b1, 32'h0,        1'b0, 0, 0, 0, 0, 0);
    run_instr(6'd5,  1'b0, 32'h0000_0015, 1'b0, 0, 0, 0, 0, 0);
    run_instr(6'd6,  1'b1, $urandom,     1'b0, 2, 3, 0, 0, 0);
    run_instr(6'd0,  1'b1, $urandom,     1'b0, 0, 0, 0, 0, 0);
    run_instr(6'd40, 1'b0, $urandom,     1'b0, 0, 0, 0, 0, 0);
    run_instr(6'd16, 1'b0, $urandom,     1'b0, 0, 0, 3, 0, 0);
    run_instr(6'd4,  1'b1, $urandom,     1'b0, 0, 0, 0, 0, 0);
    run_instr(6'd12, 1'b0, $urandom,     1'b0, 0, 0, 0, 2, 0);
    run_instr(6'd20, 1'b0, $urandom,     1'b1, 0, 0, 0, 0, 4);
    run_instr(6'd31, 1'b0, $urandom,     1'b1, 0, 0, 0, 0, 0);
    for (int t = 0; t < 40; t++) begin
      run_instr(6'($urandom_range(0, 40)), 1'($urandom), $urandom, 1'b1, 0, 0,
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 4)) : 0,
                ($urandom_range(0, 4) == 0) ? 2 : 0, 0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge CLK);
        #1;
      end
    end
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
